// File: rtl/fft_led_mapper.sv
// rtl/fft_led_mapper.sv - folds FFT magnitude bins into one peak value per LED
//
// Purpose:
//   Accepts a stream of FFT bin magnitudes, drops the low (DC) bins, and merges
//   BINS_PER_LED consecutive bins into one LED value by taking their unsigned
//   maximum. It produces exactly LED_COUNT new_flag pulses per frame. A short
//   frame is padded with zero-valued LEDs while the input is held off. Bins
//   that arrive after the last LED are dropped until fft_last.
//
// Optional feature:
//   LOG_SCALE_EN - when defined, freq_mag carries a coarse log2 code
//   {17'b0, msb_index[4:0], three bits below the msb}. When it is not
//   defined, freq_mag carries the raw group maximum.
//
// Ports:
//   clk_100mhz  in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   fft_valid   in   fft_mag / fft_last valid this cycle
//   fft_last    in   final bin of the current FFT frame
//   fft_mag     in   [24:0] magnitude of the current bin
//   fft_ready   out  bin accepted when fft_valid && fft_ready (low only while padding)
//   new_flag    out  one-cycle pulse; freq_mag holds the next LED value
//   freq_mag    out  [24:0] LED value, held between pulses
//   frame_done  out  one-cycle pulse with the LED_COUNT-th new_flag of a frame

module fft_led_mapper #(
  parameter int LED_COUNT    = 72,
  parameter int BINS_PER_LED = 4,
  parameter int START_BIN    = 1
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic        fft_last,
  input  logic [24:0] fft_mag,
  output logic        fft_ready,
  output logic        new_flag,
  output logic [24:0] freq_mag,
  output logic        frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_SKIP  = 2'd3;

  localparam int LED_W = $clog2(LED_COUNT + 1);
  localparam int GRP_W = $clog2(BINS_PER_LED + 1);
  localparam int BIN_W = $clog2(START_BIN + 2);

  localparam logic [LED_W-1:0] LED_LAST  = LED_W'(LED_COUNT - 1);
  localparam logic [GRP_W-1:0] GRP_LAST  = GRP_W'(BINS_PER_LED - 1);
  localparam logic [BIN_W-1:0] BIN_FIRST = BIN_W'(START_BIN);

  logic [1:0]       state;
  logic [LED_W-1:0] led_cnt;   // LEDs already emitted in this frame
  logic [GRP_W-1:0] grp_cnt;   // bins already merged into the open group
  logic [BIN_W-1:0] bin_cnt;   // bin index; only "below START_BIN or not" matters
  logic [24:0]      acc;       // running maximum of the open group

  logic        beat;
  logic        in_range;
  logic        grp_end;
  logic        led_end;
  logic [24:0] grp_max;

  // Output scaling applied to every emitted LED value.
  function automatic logic [24:0] scale(input logic [24:0] v);
`ifdef LOG_SCALE_EN
    logic [4:0]  p;
    logic [24:0] s;
    p = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (v[i]) p = 5'(i);
    end
    // Normalise so that the msb sits at bit 24. The three bits below it
    // then become the mantissa, zero-padded when the msb index is below 3.
    s = v << (5'd24 - p);
    if (v == 25'd0) scale = 25'd0;
    else            scale = {17'b0, p, s[23:21]};
`else
    scale = v;
`endif
  endfunction

  assign fft_ready = (state != ST_FLUSH);
  assign beat      = fft_valid && fft_ready;
  assign in_range  = (bin_cnt >= BIN_FIRST);
  // A discarded DC bin must not pollute the group maximum.
  assign grp_max   = (in_range && (fft_mag > acc)) ? fft_mag : acc;
  assign grp_end   = in_range && (grp_cnt == GRP_LAST);
  assign led_end   = (led_cnt == LED_LAST);

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state      <= ST_IDLE;
      led_cnt    <= '0;
      grp_cnt    <= '0;
      bin_cnt    <= '0;
      acc        <= '0;
      freq_mag   <= '0;
      new_flag   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      new_flag   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (beat) begin
            // The bin counter saturates once past the discard region because
            // no later decision depends on its exact value.
            bin_cnt <= fft_last ? '0 : (in_range ? bin_cnt : bin_cnt + 1'b1);
            if (grp_end || fft_last) begin
              // A full group, or the partial group closed by fft_last.
              new_flag <= 1'b1;
              freq_mag <= scale(grp_max);
              acc      <= '0;
              grp_cnt  <= '0;
              if (led_end) begin
                frame_done <= 1'b1;
                led_cnt    <= '0;
                state      <= fft_last ? ST_IDLE : ST_SKIP;
              end else begin
                led_cnt <= led_cnt + 1'b1;
                state   <= fft_last ? ST_FLUSH : ST_ACCUM;
              end
            end else begin
              acc <= grp_max;
              if (in_range) grp_cnt <= grp_cnt + 1'b1;
              state <= ST_ACCUM;
            end
          end
        end

        ST_FLUSH: begin
          // Pad with zero LEDs; the input is held off (fft_ready low).
          new_flag <= 1'b1;
          freq_mag <= scale(25'd0);
          if (led_end) begin
            frame_done <= 1'b1;
            led_cnt    <= '0;
            state      <= ST_IDLE;
          end else begin
            led_cnt <= led_cnt + 1'b1;
          end
        end

        ST_SKIP: begin
          if (beat && fft_last) begin
            bin_cnt <= '0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_led_mapper.sv
// tb/tb_fft_led_mapper.sv - scoreboard bench for fft_led_mapper
module tb_fft_led_mapper;

  localparam int LEDS = 72;

`ifdef LOG_SCALE_EN
  localparam logic [24:0] L_4   = 25'd16;
  localparam logic [24:0] L_8   = 25'd24;
  localparam logic [24:0] L_9   = 25'd25;
  localparam logic [24:0] L_288 = 25'd65;
`else
  localparam logic [24:0] L_4   = 25'd4;
  localparam logic [24:0] L_8   = 25'd8;
  localparam logic [24:0] L_9   = 25'd9;
  localparam logic [24:0] L_288 = 25'd288;
`endif

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic        fft_last = 1'b0;
  logic [24:0] fft_mag = '0;
  logic        fft_ready;
  logic        new_flag;
  logic [24:0] freq_mag;
  logic        frame_done;

  fft_led_mapper dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .fft_valid  (fft_valid),
    .fft_last   (fft_last),
    .fft_mag    (fft_mag),
    .fft_ready  (fft_ready),
    .new_flag   (new_flag),
    .freq_mag   (freq_mag),
    .frame_done (frame_done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    logic [24:0] mag;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          ready_low = 0;
  logic [24:0] cap [0:LEDS-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [24:0] exp_scale(input logic [24:0] v);
`ifdef LOG_SCALE_EN
    int          p;
    logic [24:0] t;
    if (v == 25'd0) return 25'd0;
    p = 0;
    t = v;
    while (t > 25'd1) begin
      t = t >> 1;
      p++;
    end
    if (p >= 3) return 25'(8 * p + int'((v >> (p - 3)) & 25'd7));
    else        return 25'(8 * p + int'((v << (3 - p)) & 25'd7));
`else
    return v;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever the DUT pulses new_flag.
  always @(negedge clk_100mhz) begin
    exp_t e;
    if (!fft_ready) ready_low++;
    if (frame_done) chk("frame_done_with_new_flag", new_flag, 1);
    if (new_flag) begin
      if (sb.size() == 0) begin
        chk("unexpected_new_flag", new_flag, 0);
      end else begin
        e = sb.pop_front();
        chk("freq_mag", freq_mag, e.mag);
        chk("frame_done", frame_done, e.done);
      end
      if (pulses < LEDS) cap[pulses] = freq_mag;
      pulses++;
    end
  end

  // Expected LED stream for a frame of n bins whose magnitude equals the bin index.
  task automatic expect_frame(input int n);
    exp_t        e;
    int          hi;
    int          lo;
    logic [24:0] v;
    for (int i = 0; i < LEDS; i++) begin
      hi = 4 * i + 4;
      lo = 4 * i + 1;
      if (hi <= n - 1)      v = 25'(hi);
      else if (lo <= n - 1) v = 25'(n - 1);
      else                  v = 25'd0;
      e.mag  = exp_scale(v);
      e.done = (i == LEDS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic expect_one(input logic [24:0] v);
    exp_t e;
    e.mag  = exp_scale(v);
    e.done = 1'b0;
    sb.push_back(e);
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic send(input logic [24:0] m, input logic l);
    int guard;
    guard = 0;
    fft_valid = 1'b1;
    fft_mag   = m;
    fft_last  = l;
    while (!fft_ready && guard < 200) begin
      @(posedge clk_100mhz);
      #1;
      guard++;
    end
    if (guard >= 200) chk("fft_ready_timeout", fft_ready, 1);
    @(posedge clk_100mhz);
    #1;
    fft_valid = 1'b0;
    fft_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap);
    for (int b = 0; b < n; b++) begin
      send(25'(b), b == n - 1);
      if (gap) begin
        @(posedge clk_100mhz);
        #1;
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(posedge clk_100mhz);
      #1;
      g++;
    end
    repeat (3) @(posedge clk_100mhz);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic start_frame(input int n);
    pulses    = 0;
    ready_low = 0;
    expect_frame(n);
  endtask

  initial begin
    repeat (3) @(posedge clk_100mhz);
    #1;
    chk("reset_new_flag", new_flag, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_freq_mag", freq_mag, 0);
    chk("reset_fft_ready", fft_ready, 1);
    rst = 1'b0;
    @(posedge clk_100mhz);
    #1;

    // Full 512-bin frame.
    start_frame(512);
    send_frame(512, 1'b0);
    drain();
    chk("full_pulses", pulses, LEDS);
    chk("full_ready_low", ready_low, 0);
    chk("full_led0", cap[0], L_4);
    chk("full_led1", cap[1], L_8);
    chk("full_led71", cap[71], L_288);
    chk("full_hold", freq_mag, L_288);

    // Short frame: partial group, then zero padding.
    start_frame(10);
    send_frame(10, 1'b0);
    drain();
    chk("short_pulses", pulses, LEDS);
    chk("short_ready_low", ready_low, 69);
    chk("short_led2", cap[2], L_9);
    chk("short_led3", cap[3], 0);
    chk("short_led71", cap[71], 0);

    // Last bin completes the final group exactly.
    start_frame(289);
    send_frame(289, 1'b0);
    drain();
    chk("exact_pulses", pulses, LEDS);
    chk("exact_ready_low", ready_low, 0);
    chk("exact_led71", cap[71], L_288);

    // Reset after the 3rd LED of a frame abandons the frame.
    pulses = 0;
    expect_one(25'd4);
    expect_one(25'd8);
    expect_one(25'd12);
    for (int b = 0; b <= 12; b++) send(25'(b), 1'b0);
    rst = 1'b1;
    @(posedge clk_100mhz);
    #1;
    rst = 1'b0;
    chk("rst_freq_mag", freq_mag, 0);
    chk("rst_fft_ready", fft_ready, 1);
    repeat (10) @(posedge clk_100mhz);
    #1;
    chk("rst_pulses_before_reset", pulses, 3);
    start_frame(512);
    send_frame(512, 1'b0);
    drain();
    chk("rst_new_frame_pulses", pulses, LEDS);
    chk("rst_new_frame_led0", cap[0], L_4);

    // Same data with fft_valid toggling every other cycle.
    start_frame(512);
    send_frame(512, 1'b1);
    drain();
    chk("toggle_pulses", pulses, LEDS);
    chk("toggle_led71", cap[71], L_288);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
